// File: rtl/uart_ram_loader_pkg.sv
// uart_ram_loader_pkg: state encodings, header marker and 50 MHz / 115200 baud defaults for the UART RAM loader
package uart_ram_loader_pkg;
  localparam int CLK_HZ = 50_000_000;
  localparam int BAUD = 115_200;
  localparam int CLKS_PER_BIT_DEF = CLK_HZ / BAUD;
  localparam int TIMEOUT_DEF = 5_000_000;
  localparam logic [7:0] HEADER_DEF = 8'hA5;
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [1:0] {L_IDLE, L_LEN, L_DATA, L_SUM} ld_state_t;
endpackage

// File: rtl/uart_ram_loader_rx.sv
// uart_rx_byte: 2-FF synchronised 8N1 receiver (clk, rst, rx -> rx_byte, one-cycle rx_valid / frame_err)
module uart_rx_byte
  import uart_ram_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err
);
  localparam logic [15:0] HALF = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] FULL = 16'(CLKS_PER_BIT - 1);
  rx_state_t state, state_n;
  logic [1:0] sync;
  logic [15:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] sh, sh_n;
  logic valid_n, ferr_n, rxs;
  assign rxs = sync[1];
  assign rx_byte = sh;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= 2'b11;
      state <= R_IDLE;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
      rx_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sync <= {sync[0], rx};
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      sh <= sh_n;
      rx_valid <= valid_n;
      frame_err <= ferr_n;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt + 16'd1;
    idx_n = idx;
    sh_n = sh;
    valid_n = 1'b0;
    ferr_n = 1'b0;
    case (state)
      R_IDLE: begin
        cnt_n = '0;
        state_n = rxs ? R_IDLE : R_START;
      end
      R_START: if (cnt == HALF) begin
        cnt_n = '0;
        idx_n = '0;
        state_n = rxs ? R_IDLE : R_DATA;
      end
      R_DATA: if (cnt == FULL) begin
        cnt_n = '0;
        sh_n = {rxs, sh[7:1]};
        idx_n = idx + 3'd1;
        state_n = idx == 3'd7 ? R_STOP : R_DATA;
      end
      default: if (cnt == FULL) begin
        cnt_n = '0;
        valid_n = rxs;
        ferr_n = !rxs;
        state_n = R_IDLE;
      end
    endcase
  end
endmodule

// File: rtl/uart_ram_loader.sv
// uart_ram_loader: framed UART program loader (rx -> load_addr/load_data/load_we; loading, sticky done/err, byte_cnt)
module uart_ram_loader
  import uart_ram_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF,
  parameter logic [7:0] HEADER = HEADER_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic [15:0] load_addr,
  output logic [7:0]  load_data,
  output logic        load_we,
  output logic        loading,
  output logic        done,
  output logic        err,
  output logic [7:0]  byte_cnt
);
  ld_state_t state, state_n;
  logic [7:0] rx_byte, addr, sum;
  logic rx_valid, frame_err, abort;
  logic [8:0] rem;
  logic [31:0] tmo;
  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .rx_byte(rx_byte),
    .rx_valid(rx_valid),
    .frame_err(frame_err)
  );
  assign load_addr = {8'h00, addr};
  assign abort = state != L_IDLE && (frame_err || (!rx_valid && tmo + 32'd1 == 32'(TIMEOUT_CYCLES)));
  always_ff @(posedge clk) begin
    if (rst) state <= L_IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    if (abort) state_n = L_IDLE;
    else if (rx_valid)
      case (state)
        L_IDLE: state_n = rx_byte == HEADER ? L_LEN : L_IDLE;
        L_LEN: state_n = L_DATA;
        L_DATA: state_n = rem == 9'd1 ? L_SUM : L_DATA;
        default: state_n = L_IDLE;
      endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= '0;
      load_data <= '0;
      load_we <= 1'b0;
      loading <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      byte_cnt <= '0;
      sum <= '0;
      rem <= '0;
      tmo <= '0;
    end else begin
      load_we <= rx_valid && state == L_DATA;
      tmo <= rx_valid ? 32'd1 : state == L_IDLE ? 32'd0 : tmo + 32'd1;
      if (load_we) begin
        addr <= addr + 8'd1;
        byte_cnt <= byte_cnt + 8'd1;
      end
      if (rx_valid)
        case (state)
          L_IDLE: if (rx_byte == HEADER) begin
            loading <= 1'b1;
            done <= 1'b0;
            err <= 1'b0;
            byte_cnt <= '0;
            sum <= '0;
          end
          L_LEN: begin
            rem <= {rx_byte == 8'd0, rx_byte};
            addr <= '0;
          end
          L_DATA: begin
            load_data <= rx_byte;
            sum <= sum + rx_byte;
            rem <= rem - 9'd1;
          end
          default: begin
            done <= rx_byte == sum;
            err <= rx_byte != sum;
            loading <= 1'b0;
          end
        endcase
      if (abort) begin
        err <= 1'b1;
        loading <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_ram_loader.sv
// tb_uart_ram_loader: directed and random program loads checked against a byte-level model of the loader
module tb_uart_ram_loader;
  localparam int CPB = 8;
  localparam int TMO = 100;
  logic clk = 1'b0, rst = 1'b1, rx = 1'b1;
  logic [15:0] load_addr;
  logic [7:0] load_data, byte_cnt;
  logic load_we, loading, done, err;
  int checks = 0, passed = 0, lat_bad = 0, rxv_cnt = 0;
  int unsigned cyc = 0, we_cyc = 0;
  logic prev_v = 1'b0;
  logic [15:0] wq_addr[$];
  logic [7:0] wq_data[$];
  logic [7:0] payload[$];
  always #5 clk = ~clk;
  uart_ram_loader #(.CLKS_PER_BIT(CPB), .TIMEOUT_CYCLES(TMO), .HEADER(8'hA5)) dut (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .load_addr(load_addr),
    .load_data(load_data),
    .load_we(load_we),
    .loading(loading),
    .done(done),
    .err(err),
    .byte_cnt(byte_cnt)
  );
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (load_we) begin
      wq_addr.push_back(load_addr);
      wq_data.push_back(load_data);
      we_cyc = cyc;
      if (!prev_v) lat_bad++;
    end
    if (dut.u_rx.rx_valid) rxv_cnt++;
    prev_v = dut.u_rx.rx_valid;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask
  task automatic clear_mon();
    wq_addr.delete();
    wq_data.delete();
    lat_bad = 0;
  endtask
  task automatic do_load(input string tag, input logic good);
    int n;
    logic [7:0] s;
    n = payload.size();
    s = 8'h00;
    clear_mon();
    send_byte(8'hA5);
    send_byte(8'(n));
    chk({tag, " loading"}, loading, 1);
    foreach (payload[i]) begin
      send_byte(payload[i]);
      s = s + payload[i];
    end
    send_byte(good ? s : s + 8'd1);
    repeat (4 * CPB) @(negedge clk);
    chk({tag, " nwrites"}, wq_addr.size(), n);
    for (int i = 0; i < n && i < wq_addr.size(); i++) begin
      chk($sformatf("%s addr[%0d]", tag, i), wq_addr[i], i % 256);
      chk($sformatf("%s data[%0d]", tag, i), wq_data[i], payload[i]);
    end
    chk({tag, " we latency"}, lat_bad, 0);
    chk({tag, " done"}, done, good);
    chk({tag, " err"}, err, !good);
    chk({tag, " loading end"}, loading, 0);
    chk({tag, " byte_cnt"}, byte_cnt, n % 256);
    chk({tag, " final addr"}, load_addr, n % 256);
  endtask
  initial begin
    int r;
    repeat (4) @(negedge clk);
    chk("reset outs", {load_addr, load_data, load_we, loading, done, err, byte_cnt}, 0);
    rst = 1'b0;
    repeat (2 * CPB) @(negedge clk);
    payload = '{8'h11, 8'h22, 8'h33};
    do_load("t1", 1'b1);
    payload = '{8'h10, 8'h20};
    do_load("t2", 1'b0);
    clear_mon();
    send_byte(8'h5A);
    send_byte(8'hFF);
    repeat (2 * CPB) @(negedge clk);
    chk("t3 ignored writes", wq_addr.size(), 0);
    chk("t3 ignored loading", loading, 0);
    payload = '{8'h7E};
    do_load("t3", 1'b1);
    r = rxv_cnt;
    clear_mon();
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    chk("t4 glitch rx_valid", rxv_cnt, r);
    chk("t4 glitch state", {loading, done, err}, 3'b010);
    send_byte(8'hA5);
    send_byte(8'h03);
    send_byte(8'h11);
    send_byte(8'h22, 1'b0);
    repeat (4 * CPB) @(negedge clk);
    chk("t4 frame err", {loading, done, err}, 3'b001);
    chk("t4 frame writes", wq_addr.size(), 1);
    clear_mon();
    send_byte(8'hA5);
    send_byte(8'h04);
    send_byte(8'h01);
    for (int i = 0; i < 300 && !err; i++) @(negedge clk);
    chk("t5 timeout err", {loading, done, err}, 3'b001);
    // load_we trails rx_valid by one clock, so the timeout lands 99 clocks after the strobe
    chk("t5 timeout delay", cyc - we_cyc, 99);
    for (int k = 0; k < 3; k++) begin
      payload.delete();
      repeat ($urandom_range(20, 1)) payload.push_back(8'($urandom));
      do_load($sformatf("rnd%0d", k), 1'($urandom));
    end
    payload.delete();
    for (int i = 0; i < 256; i++) payload.push_back(8'(i));
    do_load("t6", 1'b1);
    send_byte(8'hA5);
    send_byte(8'h0A);
    send_byte(8'hC3);
    send_byte(8'h3C);
    rx = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    chk("t6 pre-rst", {loading, byte_cnt}, 9'h102);
    rst = 1'b1;
    @(negedge clk);
    chk("t6 rst outs", {load_addr, load_data, load_we, loading, done, err, byte_cnt}, 0);
    rx = 1'b1;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
